// File: rtl/adc_bcd_display_if.sv
// Bundles the ADC-side pins and the display-side outputs of adc_bcd_display.
// master: the sampler itself (drives start/status/segments, reads ADC data and EOC).
// slave: the surrounding board/bench (drives ADC data and EOC, observes the rest).
interface adc_bcd_display_if #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
);
  logic [DATA_W-1:0]   d;
  logic                eoc_n;
  logic                start;
  logic                busy;
  logic                valid;
  logic                timeout;
  logic                ovf;
  logic [DIGITS*7-1:0] seg;

  modport master (
    input  d, eoc_n,
    output start, busy, valid, timeout, ovf, seg
  );

  modport slave (
    output d, eoc_n,
    input  start, busy, valid, timeout, ovf, seg
  );
endinterface

// File: rtl/adc_bcd_display.sv
// Purpose: periodic ADC trigger, EOC capture with timeout, sequential binary-to-BCD, 7-segment drive.
// Latency: seg/valid update DATA_W+1 cycles after the capture edge; capture 2 cycles after eoc_n falls.
// Backpressure: none; a period trigger arriving while busy is dropped. Macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module adc_bcd_display #(
  parameter int DATA_W  = 8,
  parameter int DIGITS  = 3,
  parameter int PERIOD  = 50000,
  parameter int START_W = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  adc_bcd_display_if.master   bus
);

  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int PH_MX1 = (START_W > TIMEOUT) ? START_W : TIMEOUT;
  localparam int PH_MAX = (PH_MX1 > DATA_W) ? PH_MX1 : DATA_W;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int BCD_W  = DIGITS * 4;
  localparam int SEG_W  = DIGITS * 7;

  // Largest value the display can show; anything above is drawn as dashes.
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [SEG_W-1:0] SEG_RST = SEG_W'(7'h3F);
`else
  localparam logic [SEG_W-1:0] SEG_RST = {DIGITS{7'h3F}};
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_EOC,
    S_CONVERT,
    S_UPDATE
  } state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Double-dabble correction: any nibble that would reach 10+ after doubling gets +3 first.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic                eoc_meta_q, eoc_meta_d;
  logic                eoc_s_q, eoc_s_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;
  logic                ovf_q, ovf_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;

  logic [BCD_W-1:0]    bcd_adj;
  logic [SEG_W-1:0]    seg_disp;
  logic                ovf_c;
`ifdef LEADING_ZERO_BLANK_EN
  logic                lead_seen;
`endif

  assign bcd_adj = bcd_adjust(bcd_q);
  assign ovf_c   = (32'(sample_q) > MAX_VAL);

  // Segment image of the finished BCD value, optionally blanking zeros above the top digit.
  always_comb begin
    seg_disp = '0;
`ifdef LEADING_ZERO_BLANK_EN
    lead_seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) lead_seen = 1'b1;
      if (lead_seen || (i == 0)) seg_disp[7*i +: 7] = seg_encode(bcd_q[4*i +: 4]);
    end
`else
    for (int i = 0; i < DIGITS; i++) begin
      seg_disp[7*i +: 7] = seg_encode(bcd_q[4*i +: 4]);
    end
`endif
  end

  // Next-state logic: period counter, EOC synchronizer and the sample/convert/update sequencer.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    start_d    = start_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    ovf_d      = ovf_q;
    seg_d      = seg_q;
    sample_d   = sample_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    eoc_meta_d = ~bus.eoc_n;
    eoc_s_d    = eoc_meta_q;

    if (cnt_q == CNT_W'(PERIOD - 1)) cnt_d = '0;
    else                             cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cnt_q == '0) begin
          state_d = S_START;
          start_d = 1'b1;
          ph_d    = '0;
        end
      end
      S_START: begin
        if (ph_q == PH_W'(START_W - 1)) begin
          start_d = 1'b0;
          state_d = S_WAIT_EOC;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_WAIT_EOC: begin
        if (eoc_s_q) begin
          sample_d = bus.d;
          shift_d  = bus.d;
          bcd_d    = '0;
          ph_d     = '0;
          state_d  = S_CONVERT;
        end else if (ph_q == PH_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_CONVERT: begin
        bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
        shift_d = {shift_q[DATA_W-2:0], 1'b0};
        if (ph_q == PH_W'(DATA_W - 1)) state_d = S_UPDATE;
        else                           ph_d    = ph_q + 1'b1;
      end
      S_UPDATE: begin
        ovf_d     = ovf_c;
        seg_d     = ovf_c ? {DIGITS{7'h40}} : seg_disp;
        valid_d   = 1'b1;
        timeout_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ph_q       <= '0;
      eoc_meta_q <= 1'b0;
      eoc_s_q    <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      ovf_q      <= 1'b0;
      seg_q      <= SEG_RST;
      sample_q   <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      eoc_meta_q <= eoc_meta_d;
      eoc_s_q    <= eoc_s_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      ovf_q      <= ovf_d;
      seg_q      <= seg_d;
      sample_q   <= sample_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
    end
  end

  assign bus.start   = start_q;
  assign bus.busy    = busy_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;
  assign bus.ovf     = ovf_q;
  assign bus.seg     = seg_q;

endmodule

// File: tb/tb_adc_bcd_display.sv
// Directed bench for adc_bcd_display: three instances (defaults-like, 10-bit, short period).
// Each table row is one sample period; reset-during-convert is a hand-written sequence.
// Expected segment images are written out by hand from the encoding table.
module tb_adc_bcd_display;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  rst_n_v;
  logic [2:0]  eoc_drv;
  logic [15:0] d_drv [3];

  logic [2:0]  st, by, vl, tm, ov;
  logic [20:0] sg [3];

  int sw  [3] = '{10, 4, 2};
  int tmo [3] = '{1000, 50, 30};
  int per [3] = '{2000, 200, 40};
  int lat [3] = '{12, 14, 12};
  int last_start [3] = '{-1, -1, -1};

  int n_vec = 0;
  int n_err = 0;

  adc_bcd_display_if #(.DATA_W(8),  .DIGITS(3)) if_a ();
  adc_bcd_display_if #(.DATA_W(10), .DIGITS(3)) if_b ();
  adc_bcd_display_if #(.DATA_W(8),  .DIGITS(3)) if_c ();

  adc_bcd_display #(.DATA_W(8), .DIGITS(3), .PERIOD(2000), .START_W(10), .TIMEOUT(1000))
    u_a (.clk(clk), .rst_n(rst_n_v[0]), .bus(if_a));
  adc_bcd_display #(.DATA_W(10), .DIGITS(3), .PERIOD(200), .START_W(4), .TIMEOUT(50))
    u_b (.clk(clk), .rst_n(rst_n_v[1]), .bus(if_b));
  adc_bcd_display #(.DATA_W(8), .DIGITS(3), .PERIOD(40), .START_W(2), .TIMEOUT(30))
    u_c (.clk(clk), .rst_n(rst_n_v[2]), .bus(if_c));

  assign if_a.d = d_drv[0][7:0];
  assign if_b.d = d_drv[1][9:0];
  assign if_c.d = d_drv[2][7:0];
  assign if_a.eoc_n = eoc_drv[0];
  assign if_b.eoc_n = eoc_drv[1];
  assign if_c.eoc_n = eoc_drv[2];

  assign st = {if_c.start,   if_b.start,   if_a.start};
  assign by = {if_c.busy,    if_b.busy,    if_a.busy};
  assign vl = {if_c.valid,   if_b.valid,   if_a.valid};
  assign tm = {if_c.timeout, if_b.timeout, if_a.timeout};
  assign ov = {if_c.ovf,     if_b.ovf,     if_a.ovf};
  assign sg[0] = if_a.seg;
  assign sg[1] = if_b.seg;
  assign sg[2] = if_c.seg;

  typedef struct {
    int          inst;
    logic [15:0] d;
    bit          no_eoc;
    int          dly;
    int          exp_int;
    logic [20:0] exp_seg;
    bit          exp_ovf;
    bit          exp_tmo;
  } vec_t;

  vec_t vt [12];

  function automatic logic [6:0] z(input logic [6:0] x);
    return LZB ? 7'h00 : x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_rise(input int i, output bit ok);
    logic prev;
    prev = st[i];
    ok = 1'b0;
    for (int n = 0; n < 2 * per[i] + 20; n++) begin
      @(negedge clk);
      if (st[i] && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = st[i];
    end
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int   i, w, n, t0;
    bit   ok;
    v = vt[k];
    i = v.inst;
    wait_rise(i, ok);
    chk($sformatf("v%0d_start_rise", k), 32'(ok), 32'd1);
    if (!ok) return;
    t0 = cyc;
    if (last_start[i] >= 0) chk($sformatf("v%0d_start_interval", k), t0 - last_start[i], v.exp_int);
    last_start[i] = t0;
    w = 0;
    while (st[i] && w < 1000) begin
      w++;
      @(negedge clk);
    end
    chk($sformatf("v%0d_start_width", k), w, sw[i]);
    if (v.no_eoc) begin
      n = 0;
      while (!tm[i] && n < tmo[i] + sw[i] + 50) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d_timeout_time", k), cyc - t0, sw[i] + tmo[i]);
    end else begin
      repeat (v.dly) @(negedge clk);
      d_drv[i]   = v.d;
      eoc_drv[i] = 1'b0;
      n = 0;
      while (!vl[i] && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d_eoc_to_valid", k), n, lat[i]);
    end
    chk($sformatf("v%0d_seg", k), 32'(sg[i]), 32'(v.exp_seg));
    chk($sformatf("v%0d_ovf", k), 32'(ov[i]), 32'(v.exp_ovf));
    chk($sformatf("v%0d_timeout", k), 32'(tm[i]), 32'(v.exp_tmo));
    chk($sformatf("v%0d_busy_after", k), 32'(by[i]), 32'd0);
    chk($sformatf("v%0d_no_start", k), 32'(st[i]), 32'd0);
    eoc_drv[i] = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_valid_once", k), 32'(vl[i]), 32'd0);
  endtask

  task automatic chk_reset(input int i, input string tag);
    chk($sformatf("%s_start", tag),   32'(st[i]), 32'd0);
    chk($sformatf("%s_busy", tag),    32'(by[i]), 32'd0);
    chk($sformatf("%s_valid", tag),   32'(vl[i]), 32'd0);
    chk($sformatf("%s_timeout", tag), 32'(tm[i]), 32'd0);
    chk($sformatf("%s_ovf", tag),     32'(ov[i]), 32'd0);
    chk($sformatf("%s_seg", tag),     32'(sg[i]), 32'({z(7'h3F), z(7'h3F), 7'h3F}));
  endtask

  initial begin
    int  n;
    bit  ok;

    //        inst  d        no_eoc dly exp_int seg                                ovf   tmo
    vt[0]  = '{0, 16'd255,  1'b0, 20, 2000, {7'h5B, 7'h6D, 7'h6D},             1'b0, 1'b0};
    vt[1]  = '{0, 16'd0,    1'b0, 20, 2000, {z(7'h3F), z(7'h3F), 7'h3F},       1'b0, 1'b0};
    vt[2]  = '{0, 16'd9,    1'b0, 20, 2000, {z(7'h3F), z(7'h3F), 7'h6F},       1'b0, 1'b0};
    vt[3]  = '{0, 16'd0,    1'b1, 0,  2000, {z(7'h3F), z(7'h3F), 7'h6F},       1'b0, 1'b1};
    vt[4]  = '{0, 16'd42,   1'b0, 20, 2000, {z(7'h3F), 7'h66, 7'h5B},          1'b0, 1'b0};
    vt[5]  = '{0, 16'd100,  1'b0, 20, 2000, {7'h06, 7'h3F, 7'h3F},             1'b0, 1'b0};
    vt[6]  = '{1, 16'd1000, 1'b0, 5,  200,  {7'h40, 7'h40, 7'h40},             1'b1, 1'b0};
    vt[7]  = '{1, 16'd999,  1'b0, 5,  200,  {7'h6F, 7'h6F, 7'h6F},             1'b0, 1'b0};
    vt[8]  = '{1, 16'd5,    1'b0, 5,  200,  {z(7'h3F), z(7'h3F), 7'h6D},       1'b0, 1'b0};
    vt[9]  = '{2, 16'd77,   1'b0, 26, 40,   {z(7'h3F), 7'h07, 7'h07},          1'b0, 1'b0};
    vt[10] = '{2, 16'd200,  1'b0, 5,  80,   {7'h5B, 7'h3F, 7'h3F},             1'b0, 1'b0};
    vt[11] = '{2, 16'd200,  1'b0, 5,  40,   {7'h5B, 7'h3F, 7'h3F},             1'b0, 1'b0};

    rst_n_v = 3'b000;
    eoc_drv = 3'b111;
    for (int i = 0; i < 3; i++) d_drv[i] = 16'd0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_reset(i, $sformatf("reset%0d", i));

    rst_n_v[0] = 1'b1;
    for (int k = 0; k <= 5; k++) run_vec(k);

    @(negedge clk);
    rst_n_v[1] = 1'b1;
    for (int k = 6; k <= 8; k++) run_vec(k);

    @(negedge clk);
    rst_n_v[2] = 1'b1;
    for (int k = 9; k <= 10; k++) run_vec(k);

    // Reset pulse in the middle of a conversion of 200.
    wait_rise(2, ok);
    chk("rst_seq_rise", 32'(ok), 32'd1);
    n = 0;
    while (st[2] && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    d_drv[2]   = 16'd200;
    eoc_drv[2] = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_seq_busy_in_convert", 32'(by[2]), 32'd1);
    rst_n_v[2] = 1'b0;
    #1;
    chk_reset(2, "rst_seq");
    eoc_drv[2] = 1'b1;
    @(negedge clk);
    rst_n_v[2] = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (vl[2]) n++;
    end
    chk("rst_seq_no_valid", n, 0);
    last_start[2] = -1;
    run_vec(11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_bcd_display.md
Name: adc_bcd_display

Overview:
- Periodically triggers an external parallel-output ADC with a start pulse and waits for its active-low end-of-conversion strobe.
- Captures the sample, converts it to BCD sequentially (shift-and-add-3), and drives one 7-segment pattern per decimal digit.
- Parametrised successor of the fixed 8-bit, 3-digit sampler: adds width/digit generality, an EOC handshake with timeout, and overflow indication.
- Sits between the ADC pins and the board 7-segment drivers.

Parameters:
- DATA_W, 8, ADC sample width in bits (2..16).
- DIGITS, 3, number of decimal digits displayed (1..5).
- PERIOD, 50000, sample period in clk cycles; must exceed START_W+TIMEOUT+DATA_W+8.
- START_W, 10, start pulse width in clk cycles (>=1).
- TIMEOUT, 1000, maximum clk cycles in WAIT_EOC before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d  in  DATA_W  ADC parallel data, stable while eoc_n low.
- eoc_n  in  1  ADC end-of-conversion, active low, asynchronous to clk.
- start  out  1  ADC start-conversion pulse, active high, registered.
- busy  out  1  high in every state except IDLE.
- valid  out  1  one-cycle pulse when seg updates.
- timeout  out  1  sticky; set on EOC timeout, cleared on the next successful update.
- ovf  out  1  high when the last captured sample exceeds 10^DIGITS-1.
- seg  out  DIGITS*7  segment patterns, active high, bit order gfedcba; seg[6:0] = units, seg[13:7] = tens, and so on.

Behaviour:
- Reset (async, rst_n low): period counter 0, FSM IDLE, start 0, busy 0, valid 0, timeout 0, ovf 0, every seg digit 7'h3F.
- Period counter:
  - Free-running 0..PERIOD-1, then wraps to 0.
  - Runs in every state.
- eoc_n path: 2-flop synchronizer into eoc_s (active-high internal). An eoc_n falling edge is seen by the FSM 2 cycles later.
- FSM states: IDLE, START, WAIT_EOC, CONVERT, UPDATE.
  - IDLE: on an edge where counter==0, go to START and set start<=1.
  - START: start held high for exactly START_W cycles, then start<=0 and go to WAIT_EOC; wait counter cleared.
  - WAIT_EOC:
    - If eoc_s=1, latch d into sample register, go to CONVERT.
    - Else if wait counter reaches TIMEOUT-1, set timeout<=1 and go to IDLE; seg and ovf unchanged.
  - CONVERT: DATA_W cycles of shift-and-add-3 on a DIGITS*4-bit BCD register plus a DATA_W shift register. Before each shift, add 3 to every nibble >=5. The BCD register is wide enough to hold 10^DIGITS-1.
  - UPDATE: one cycle, then go to IDLE. In this cycle:
    - ovf <= (sample > 10^DIGITS-1), compared against a compile-time constant.
    - If ovf, every digit <= 7'h40 (dash); else each digit <= encode(nibble).
    - valid<=1 for this cycle; timeout<=0.
- Encoding table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibbles above 9 never occur when ovf=0.
- Latency: seg/valid change on the edge DATA_W+1 cycles after the capture edge.
- Period wrap while busy: that trigger is skipped; the next start is issued only at a counter==0 edge seen in IDLE.
- eoc_n already low on entry to WAIT_EOC: captured on the first WAIT_EOC cycle.
- Reset asserted mid-operation: immediate return to reset values; any conversion in progress is discarded.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the most significant non-zero digit show 7'h00.
  - The units digit is always shown, so value 0 displays only "0".
  - Reset value: units 7'h3F, all other digits 7'h00.
  - Overflow dashes are unaffected.
- Undefined: all digits are always displayed, including leading zeros (0 shows as 3F 3F 3F).

Test Plan:
- Defaults, d=255, eoc_n pulled low 20 cycles after start falls -> start high exactly 10 cycles; seg = {5B,6D,6D}; valid pulses once; busy low after UPDATE.
- Defaults, d=0 then d=9 on successive periods -> {3F,3F,3F} then {3F,3F,6F}; with LEADING_ZERO_BLANK_EN: {00,00,3F} then {00,00,6F}.
- eoc_n held high -> timeout=1 after 10+1000 cycles; seg unchanged; start reissued at next counter wrap; next good sample d=42 clears timeout and gives {3F,66,5B}.
- DATA_W=10, DIGITS=3, d=1000 -> ovf=1, seg={40,40,40}; next sample d=999 -> ovf=0, seg={6F,6F,6F}.
- PERIOD=40, TIMEOUT=30, eoc_n delayed past the counter wrap -> no second start pulse during WAIT_EOC; the next start aligns to the following counter==0 in IDLE.
- rst_n pulsed low during CONVERT with d=200 -> all outputs return to reset values immediately; no valid pulse; next cycle shows {5B,3F,3F} normally.
